// File: rtl/crc_pkg.sv
// Shared types and constants for the reflected (LSB-first) CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_HOLD,
        ST_SHIFT
    } crc_state_e;

    // Reflected forms of common generator polynomials.
    localparam logic [7:0]  CRC8_MAXIM       = 8'h8C;
    localparam logic [7:0]  CRC8_CCITT_REFL  = 8'hE0;
    localparam logic [15:0] CRC16_CCITT_REFL = 16'h8408;

endpackage

// File: rtl/crc_engine_if.sv
// Frame input / CRC output bundle; master drives frames, slave is the engine.
interface crc_engine_if #(
    parameter int CRC_WIDTH = 8,
    parameter int DIN_WIDTH = 1
);

    logic [DIN_WIDTH-1:0] data;
    logic                 Active;
    logic                 enable;
    logic                 CRC;
    logic                 Valid;
    logic [CRC_WIDTH-1:0] CRC_PAR;
    logic                 Done;

    modport master (
        output data, Active, enable,
        input  CRC, Valid, CRC_PAR, Done
    );

    modport slave (
        input  data, Active, enable,
        output CRC, Valid, CRC_PAR, Done
    );

endinterface

// File: rtl/crc_engine_step.sv
// Combinational multi-bit CRC update: applies the per-bit LFSR step to
// data_i[0] .. data_i[DIN_WIDTH-1] in order.
module crc_step
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC8_MAXIM,
    parameter int                   DIN_WIDTH = 1
) (
    input  logic [CRC_WIDTH-1:0] crc_i,
    input  logic [DIN_WIDTH-1:0] data_i,
    output logic [CRC_WIDTH-1:0] crc_o
);

    logic [CRC_WIDTH-1:0] acc;

    // NOTE: blocking assignments are deliberate here so each bit's update
    // sees the result of the previous bit within the same cycle.
    always_comb begin
        acc = crc_i;
        for (int i = 0; i < DIN_WIDTH; i++) begin
            if (acc[0] ^ data_i[i]) begin
                acc = (acc >> 1) ^ POLY;
            end else begin
                acc = acc >> 1;
            end
        end
        crc_o = acc;
    end

endmodule

// File: rtl/crc_engine.sv
// Reflected CRC engine: accumulates a frame while Active is high, then
// presents the result in parallel and shifts it out serially, LSB first.
module crc_engine
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC8_MAXIM,
    parameter logic [CRC_WIDTH-1:0] SEED      = '0,
    parameter int                   DIN_WIDTH = 1,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT   = '0
) (
    input logic          CLK,
    input logic          RST,
    crc_engine_if.slave  bus
);

    localparam int CNT_W = $clog2(CRC_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_WIDTH - 1);

    crc_state_e           state_q;
    logic [CRC_WIDTH-1:0] crc_q;
    logic [CRC_WIDTH-1:0] par_q;
    logic [CRC_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [CRC_WIDTH-1:0] step_in;
    logic [CRC_WIDTH-1:0] crc_d;

    // A new frame (from IDLE or an abandoned HOLD) always starts from SEED.
    assign step_in = (state_q == ST_CALC) ? crc_q : SEED;

    crc_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLY      (POLY),
        .DIN_WIDTH (DIN_WIDTH)
    ) u_step (
        .crc_i  (step_in),
        .data_i (bus.data),
        .crc_o  (crc_d)
    );

    // NOTE: non-blocking assignments for every sequential register so all
    // flops update together from the pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            crc_q   <= SEED;
            par_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.Active) begin
                        crc_q   <= crc_d;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (bus.Active) begin
                        crc_q <= crc_d;
                    end else begin
                        par_q   <= crc_q ^ XOR_OUT;
                        shreg_q <= crc_q ^ XOR_OUT;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.Active) begin
                        crc_q   <= crc_d;
                        state_q <= ST_CALC;
                    end else if (bus.enable) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.enable) begin
                        shreg_q <= shreg_q >> 1;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from flops; no input reaches an output.
    assign bus.Valid   = (state_q == ST_SHIFT);
    assign bus.Done    = (state_q == ST_HOLD) || (state_q == ST_SHIFT);
    assign bus.CRC     = (state_q == ST_SHIFT) && shreg_q[0];
    assign bus.CRC_PAR = par_q;

endmodule

// File: tb/tb_crc_engine.sv
// Directed self-checking bench for crc_engine: bit-serial CRC-8/MAXIM,
// byte-wide CRC-8/MAXIM and byte-wide CRC-16/X-25 instances.
module tb_crc_engine;
    import crc_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    crc_engine_if #(.CRC_WIDTH(8),  .DIN_WIDTH(1)) if_d1 ();
    crc_engine_if #(.CRC_WIDTH(8),  .DIN_WIDTH(8)) if_d8 ();
    crc_engine_if #(.CRC_WIDTH(16), .DIN_WIDTH(8)) if_x25 ();

    crc_engine u_d1 (
        .CLK (CLK),
        .RST (RST),
        .bus (if_d1)
    );

    crc_engine #(
        .DIN_WIDTH (8)
    ) u_d8 (
        .CLK (CLK),
        .RST (RST),
        .bus (if_d8)
    );

    crc_engine #(
        .CRC_WIDTH (16),
        .POLY      (CRC16_CCITT_REFL),
        .SEED      (16'hFFFF),
        .DIN_WIDTH (8),
        .XOR_OUT   (16'hFFFF)
    ) u_x25 (
        .CLK (CLK),
        .RST (RST),
        .bus (if_x25)
    );

    int total = 0;
    int bad   = 0;
    int d1_valid_seen = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Sends one byte LSB first on the serial instance, then drops Active.
    task automatic d1_send(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if_d1.Active = 1'b1;
            if_d1.data   = b[i];
            tick();
            if (if_d1.Valid) d1_valid_seen++;
        end
        if_d1.Active = 1'b0;
        if_d1.data   = 1'b0;
        tick();
        if (if_d1.Valid) d1_valid_seen++;
    endtask

    // From HOLD: shifts the CRC out, pausing enable for stall_len Valid
    // cycles starting at Valid cycle index stall_at. Bounded to 40 cycles.
    task automatic d1_shift(input int stall_at, input int stall_len,
                            output logic [7:0] val, output int nvalid);
        int nb;
        nb     = 0;
        nvalid = 0;
        val    = '0;
        for (int c = 0; c < 40; c++) begin
            logic en;
            if (!if_d1.Valid && nvalid > 0) break;
            en = !(if_d1.Valid && nvalid >= stall_at && nvalid < stall_at + stall_len);
            if (if_d1.Valid && en && nb < 8) begin
                val[nb] = if_d1.CRC;
                nb++;
            end
            if (if_d1.Valid) nvalid++;
            if_d1.enable = en;
            tick();
        end
        if_d1.enable = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int         n;
        string      msg;

        if_d1.data  = '0; if_d1.Active  = 1'b0; if_d1.enable  = 1'b0;
        if_d8.data  = '0; if_d8.Active  = 1'b0; if_d8.enable  = 1'b0;
        if_x25.data = '0; if_x25.Active = 1'b0; if_x25.enable = 1'b0;
        RST = 1'b1;
        tick();
        tick();

        check("rst_valid",   32'(if_d1.Valid),    32'h0);
        check("rst_done",    32'(if_d1.Done),     32'h0);
        check("rst_crc",     32'(if_d1.CRC),      32'h0);
        check("rst_par",     32'(if_d1.CRC_PAR),  32'h0);
        check("rst_par_d8",  32'(if_d8.CRC_PAR),  32'h0);
        check("rst_par_x25", 32'(if_x25.CRC_PAR), 32'h0);
        RST = 1'b0;
        tick();
        check("idle_done", 32'(if_d1.Done), 32'h0);

        // Byte 0x01 bit-serially, shifted out with enable held high.
        d1_send(8'h01);
        check("b01_done",  32'(if_d1.Done),    32'h1);
        check("b01_valid", 32'(if_d1.Valid),   32'h0);
        check("b01_par",   32'(if_d1.CRC_PAR), 32'h5E);
        d1_shift(99, 0, v, n);
        check("b01_serial", 32'(v), 32'h5E);
        check("b01_nvalid", 32'(n), 32'd8);
        check("b01_idle_done", 32'(if_d1.Done), 32'h0);
        check("b01_par_stable", 32'(if_d1.CRC_PAR), 32'h5E);

        // Same byte with a 5-cycle HOLD wait and a 3-cycle stall mid-shift.
        d1_send(8'h01);
        for (int i = 0; i < 5; i++) tick();
        check("hold_wait_valid", 32'(if_d1.Valid), 32'h0);
        check("hold_wait_done",  32'(if_d1.Done),  32'h1);
        d1_shift(4, 3, v, n);
        check("stall_serial", 32'(v), 32'h5E);
        check("stall_nvalid", 32'(n), 32'd11);

        // Reset after the third data bit of a frame.
        if_d1.Active = 1'b1;
        if_d1.data = 1'b1; tick();
        if_d1.data = 1'b0; tick();
        if_d1.data = 1'b0; tick();
        RST = 1'b1;
        tick();
        check("midrst_done",  32'(if_d1.Done),    32'h0);
        check("midrst_valid", 32'(if_d1.Valid),   32'h0);
        check("midrst_crc",   32'(if_d1.CRC),     32'h0);
        check("midrst_par",   32'(if_d1.CRC_PAR), 32'h0);
        RST = 1'b0;
        if_d1.Active = 1'b0;
        tick();
        check("postrst_done", 32'(if_d1.Done), 32'h0);
        d1_send(8'h01);
        check("postrst_par", 32'(if_d1.CRC_PAR), 32'h5E);

        // Now in HOLD with 0x5E pending: restart with 0x80 instead.
        d1_valid_seen = 0;
        d1_send(8'h80);
        check("restart_par",     32'(if_d1.CRC_PAR),  32'h8C);
        check("restart_novalid", 32'(d1_valid_seen),  32'h0);
        d1_shift(99, 0, v, n);
        check("restart_serial", 32'(v), 32'h8C);
        check("restart_nvalid", 32'(n), 32'd8);

        // Byte-wide instance: single-cycle frames, second one restarts from HOLD.
        if_d8.Active = 1'b1; if_d8.data = 8'h80; tick();
        if_d8.Active = 1'b0; if_d8.data = 8'h00; tick();
        check("d8_80_par",  32'(if_d8.CRC_PAR), 32'h8C);
        check("d8_80_done", 32'(if_d8.Done),    32'h1);
        if_d8.Active = 1'b1; if_d8.data = 8'h01; tick();
        if_d8.Active = 1'b0; if_d8.data = 8'h00; tick();
        check("d8_01_par",   32'(if_d8.CRC_PAR), 32'h5E);
        check("d8_01_done",  32'(if_d8.Done),    32'h1);
        check("d8_01_valid", 32'(if_d8.Valid),   32'h0);

        // CRC-16/X-25 check string.
        msg = "123456789";
        for (int i = 0; i < 9; i++) begin
            if_x25.Active = 1'b1;
            if_x25.data   = msg[i];
            tick();
        end
        if_x25.Active = 1'b0;
        if_x25.data   = 8'h00;
        tick();
        check("x25_par",  32'(if_x25.CRC_PAR), 32'h906E);
        check("x25_done", 32'(if_x25.Done),    32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 Parameter CRC_WIDTH, default 8: CRC register width in bits, legal range 4..32.
REQ-002 Parameter POLY, default 8'h8C: generator polynomial in reflected (LSB-first) form, CRC_WIDTH bits.
REQ-003 Parameter SEED, default 8'h00: CRC register value loaded at frame start, CRC_WIDTH bits.
REQ-004 Parameter DIN_WIDTH, default 1: data bits consumed per cycle, legal values 1, 2, 4 and 8.
REQ-005 Parameter XOR_OUT, default 8'h00: value XORed into the final CRC before it is presented, CRC_WIDTH bits.
REQ-006 CLK  input  1: single clock, all state changes on its rising edge.
REQ-007 RST  input  1: synchronous, active-high reset.
REQ-008 data  input  DIN_WIDTH: frame data, bit 0 is processed first.
REQ-009 Active  input  1: frame-in-progress qualifier, one data word consumed per cycle while high.
REQ-010 enable  input  1: permission to shift the CRC out serially; deasserting it pauses the shift.
REQ-011 CRC  output  1: serial CRC bit, LSB first.
REQ-012 Valid  output  1: high while CRC carries a CRC bit (SHIFT state).
REQ-013 CRC_PAR  output  CRC_WIDTH: parallel final CRC, stable from frame end until the next frame start.
REQ-014 Done  output  1: high in HOLD and SHIFT, meaning CRC_PAR is valid.

Function
REQ-015 The block SHALL apply this per-bit update: fb = b ^ crc[0]; crc = (crc >> 1) ^ (fb ? POLY : 0).
REQ-016 Each cycle with Active=1 SHALL apply the per-bit update to data[0] through data[DIN_WIDTH-1], in that order, within that single cycle.
REQ-017 The state machine SHALL have four states: IDLE, CALC, HOLD and SHIFT.
REQ-018 IDLE with Active=1 SHALL start from SEED, apply the update to the current data word, and move to CALC.
REQ-019 IDLE with Active=0 SHALL leave all outputs at their reset values.
REQ-020 CALC with Active=1 SHALL update crc with the current data word.
REQ-021 CALC with Active=0 SHALL load CRC_PAR and the shift register with crc ^ XOR_OUT and move to HOLD; data is ignored in this cycle.
REQ-022 HOLD with enable=1 SHALL move to SHIFT with the bit counter cleared; with enable=0 it SHALL wait indefinitely.
REQ-023 In SHIFT, CRC SHALL equal shift_reg[0] and Valid SHALL be 1.
REQ-024 Each SHIFT cycle with enable=1 SHALL shift the register right and increment the counter; at counter = CRC_WIDTH-1 the block SHALL return to IDLE.
REQ-025 A SHIFT cycle with enable=0 SHALL hold the bit and the counter, with Valid remaining 1.
REQ-026 Serial output latency: the first CRC bit SHALL appear 2 cycles after the cycle in which Active is sampled low, provided enable=1.
REQ-027 Active=1 in HOLD SHALL abandon the pending CRC and start a new frame exactly as REQ-018 does; Active in SHIFT SHALL be ignored.
REQ-028 A frame of exactly one Active cycle SHALL be legal.
REQ-029 Frame length SHALL be unbounded, with no internal length counter.

Reset
REQ-030 RST=1 at a clock edge SHALL force: state IDLE, crc register = SEED, CRC_PAR = 0, shift register = 0, counter = 0, CRC = 0, Valid = 0, Done = 0.
REQ-031 RST SHALL take precedence over every input in every state, including mid-frame and mid-shift; no partial CRC survives reset.

Structure
REQ-032 A shared package crc_pkg SHALL hold the state enumeration and named polynomial constants (CRC8_MAXIM = 8'h8C, CRC8_CCITT_REFL = 8'hE0, CRC16_CCITT_REFL = 16'h8408).
REQ-033 The multi-bit update SHALL be a combinational sub-module crc_step, parameterised by CRC_WIDTH, POLY and DIN_WIDTH, instantiated once.
REQ-034 All outputs SHALL be registered or decoded directly from state flops; no input-to-output combinational paths are permitted.

Verification
REQ-035 Defaults, DIN_WIDTH=1, byte 8'h01 sent over 8 Active cycles, then enable=1 -> CRC_PAR = 8'h5E; serial bits 0,1,1,1,1,0,1,0 with Valid high for exactly 8 cycles.
REQ-036 DIN_WIDTH=8, single Active cycle with data=8'h80 -> CRC_PAR = 8'h8C, Done=1; byte 8'h01 -> 8'h5E, matching the serial result of REQ-035.
REQ-037 Byte 8'h01 with enable held low 5 cycles in HOLD, then dropped for 3 cycles after the 4th shifted bit -> bit sequence identical to REQ-035, with Valid high for 11 cycles in total.
REQ-038 RST=1 pulsed after the 3rd data bit of a frame, then a clean 8'h01 frame -> outputs 0 during reset, then 8'h5E.
REQ-039 Active reasserted in HOLD with a new byte 8'h80 -> CRC_PAR = 8'h8C; the old CRC 8'h5E is never shifted out.
REQ-040 CRC_WIDTH=16, POLY=16'h8408, SEED=16'hFFFF, XOR_OUT=16'hFFFF, ASCII "123456789" at DIN_WIDTH=8 -> CRC_PAR = 16'h906E (CRC-16/X-25).
